tracer_frame_sequencer: RTL and testbench

Frame-level scheduler between the per-pixel ray tracer core and the pixel RAM. On each frame request it walks the 128×64 block grid in row-major order, issues one coordinate at a time to the tracer over a valid/ready handshake, collects the 12-bit colour, and writes it to the pixel RAM write port as `{col,row}` addressed words. It handles tracer timeouts with a fallback colour. At frame completion it reports done and flips the buffer-select bit.

---
 rtl/tracer_pkg.sv | 13 +
 rtl/pixel_scan_counter.sv | 28 ++
 rtl/tracer_frame_sequencer.sv | 81 ++++++++
 tb/tb_tracer_frame_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tracer_pkg.sv
// tracer_pkg: shared geometry, colour constants, sequencer states and pixel address packing
package tracer_pkg;
  localparam int COLS = 128;
  localparam int ROWS = 64;
  localparam int COL_W = 7;
  localparam int ROW_W = 6;
  localparam int COLOR_W = 12;
  localparam logic [COLOR_W-1:0] ERR_COLOR = 12'hF0F;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} seq_state_t;
  function automatic logic [COL_W+ROW_W-1:0] pix_addr(input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row);
    return {col, row};
  endfunction
endpackage

// File: rtl/pixel_scan_counter.sv
// pixel_scan_counter: row-major col/row walker over the block grid
module pixel_scan_counter
  import tracer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last
);
  logic col_end;
  assign col_end = col == COL_W'(COLS - 1);
  assign last = col_end && row == ROW_W'(ROWS - 1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (clear) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      col <= col + COL_W'(1);
      row <= row + ROW_W'(col_end);
    end
  end
endmodule

// File: rtl/tracer_frame_sequencer.sv
// tracer_frame_sequencer: walks the block grid, requests colours from the tracer and writes them to pixel RAM
module tracer_frame_sequencer
  import tracer_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   frame_start,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [COL_W-1:0]       req_col,
  output logic [ROW_W-1:0]       req_row,
  input  logic                   rsp_valid,
  input  logic [COLOR_W-1:0]     rsp_color,
  output logic                   wr_en,
  output logic [COL_W+ROW_W-1:0] wr_addr,
  output logic [COLOR_W-1:0]     wr_data,
  output logic                   buf_sel,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   frame_overrun,
  output logic [7:0]             err_cnt
);
  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  seq_state_t state, state_nxt;
  logic [TMR_W-1:0] timer;
  logic [COLOR_W-1:0] color;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic last, timeout;
  pixel_scan_counter u_scan (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == S_IDLE && frame_start),
    .advance (state == S_WRITE),
    .col     (col),
    .row     (row),
    .last    (last)
  );
  // The last permitted WAIT cycle; a response arriving in it still wins
  assign timeout = timer == TMR_W'(TIMEOUT - 1);
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = frame_start ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nxt = req_ready ? S_WAIT : S_ISSUE;
      S_WAIT:  state_nxt = (rsp_valid || timeout) ? S_WRITE : S_WAIT;
      S_WRITE: state_nxt = last ? S_DONE : S_ISSUE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      timer   <= '0;
      color   <= '0;
      err_cnt <= '0;
      buf_sel <= 1'b0;
    end else begin
      state   <= state_nxt;
      timer   <= state == S_WAIT ? timer + TMR_W'(1) : '0;
      buf_sel <= buf_sel ^ (state == S_DONE);
      if (state == S_WAIT && rsp_valid) begin
        color <= rsp_color;
      end else if (state == S_WAIT && timeout) begin
        color   <= ERR_COLOR;
        err_cnt <= err_cnt + 8'(err_cnt != 8'hFF);
      end
    end
  end
  assign req_valid     = state == S_ISSUE;
  assign req_col       = col;
  assign req_row       = row;
  assign wr_en         = state == S_WRITE;
  assign wr_addr       = wr_en ? pix_addr(col, row) : '0;
  assign wr_data       = wr_en ? color : '0;
  assign busy          = state != S_IDLE;
  assign frame_done    = state == S_DONE;
  assign frame_overrun = frame_start && busy;
endmodule

// File: tb/tb_tracer_frame_sequencer.sv
// tb_tracer_frame_sequencer: randomized tracer model with a scoreboard of expected pixel writes
module tb_tracer_frame_sequencer;
  logic clk = 0, rst = 0, frame_start = 0, req_ready = 0, rsp_valid = 0;
  logic [11:0] rsp_color = '0;
  logic req_valid, wr_en, buf_sel, busy, frame_done, frame_overrun;
  logic [6:0] req_col;
  logic [5:0] req_row;
  logic [12:0] wr_addr;
  logic [11:0] wr_data;
  logic [7:0] err_cnt;
  typedef struct {int pix; logic [12:0] addr; logic [11:0] data; bit to;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, pix = 0, mode = 0, silent_pix = -1, edge_pix = -1, wr_count = 0;
  logic [12:0] log_addr [8192];
  logic [11:0] log_data [8192];
  always #5 clk = ~clk;
  tracer_frame_sequencer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .req_valid(req_valid), .req_ready(req_ready), .req_col(req_col), .req_row(req_row),
    .rsp_valid(rsp_valid), .rsp_color(rsp_color),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .buf_sel(buf_sel), .busy(busy), .frame_done(frame_done),
    .frame_overrun(frame_overrun), .err_cnt(err_cnt)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Tracer model: accepts requests, answers after a chosen delay, and records what must be written
  initial begin
    bit acc, pending;
    int k, rsp_at;
    logic [6:0] c;
    logic [5:0] r;
    logic [11:0] rc;
    exp_t e;
    pending = 0; k = 0; rsp_at = 0; rc = '0;
    forever begin
      @(negedge clk);
      acc = req_valid && req_ready && rst;
      @(posedge clk);
      #1;
      rsp_valid = 0;
      if (!rst) begin
        pix = 0;
        pending = 0;
      end else begin
        if (acc) begin
          c = 7'(pix % 128);
          r = 6'(pix / 128);
          rc = mode == 0 ? {r, c[5:0]} : (pix == edge_pix ? 12'h5A5 : 12'($urandom));
          rsp_at = pix == silent_pix ? 1025 : pix == edge_pix ? 1024 : mode == 0 ? 1 : int'($urandom_range(1, 2));
          e.pix = pix;
          e.addr = {c, r};
          e.data = rsp_at <= 1024 ? rc : 12'hF0F;
          e.to = rsp_at > 1024;
          q.push_back(e);
          pix = (pix + 1) % 8192;
          k = 0;
          pending = 1;
        end
        if (pending) begin
          k++;
          if (k == rsp_at) begin
            rsp_valid = 1;
            rsp_color = rc;
            pending = 0;
          end
        end
      end
      req_ready = mode == 0 ? 1'b1 : ($urandom_range(0, 7) != 0);
    end
  end
  // Compare process: frame-level expectations checked every cycle
  initial begin
    bit exp_busy, exp_buf, exp_done, start_prev, done_prev, fin_prev;
    int exp_err;
    exp_t e;
    exp_busy = 0; exp_buf = 0; exp_done = 0; start_prev = 0; done_prev = 0; fin_prev = 0; exp_err = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        q.delete();
        exp_busy = 0; exp_buf = 0; start_prev = 0; done_prev = 0; fin_prev = 0; exp_err = 0;
        chk("outputs_in_reset", 32'({req_valid, wr_en, wr_addr, wr_data, buf_sel, busy, frame_done, frame_overrun, err_cnt, req_col, req_row}), 0);
      end else begin
        if (done_prev) begin
          exp_busy = 0;
          exp_buf = ~exp_buf;
        end
        if (start_prev) exp_busy = 1;
        exp_done = fin_prev;
        done_prev = exp_done;
        fin_prev = 0;
        chk("busy", busy, exp_busy);
        chk("frame_done", frame_done, exp_done);
        chk("buf_sel", buf_sel, exp_buf);
        chk("frame_overrun", frame_overrun, frame_start && exp_busy);
        start_prev = frame_start && !exp_busy;
        if (!exp_busy) chk("idle_quiet", {req_valid, wr_en}, 0);
        if (wr_en) begin
          if (q.size() == 0) chk("unexpected_write", wr_en, 0);
          else begin
            e = q.pop_front();
            chk("wr_addr", wr_addr, e.addr);
            chk("wr_data", wr_data, e.data);
            if (e.to) exp_err = exp_err < 255 ? exp_err + 1 : 255;
            log_addr[e.pix] = wr_addr;
            log_data[e.pix] = wr_data;
            fin_prev = e.pix == 8191;
            wr_count++;
          end
        end
        chk("err_cnt", err_cnt, exp_err);
        if (req_valid) begin
          chk("req_col", req_col, pix % 128);
          chk("req_row", req_row, pix / 128);
        end
      end
    end
  end
  task automatic run_frame(input int ovr_at, input int limit, output int n);
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    chk("issue_after_start", req_valid, 1);
    n = 1;
    while (!frame_done && n < limit) begin
      @(posedge clk); #1;
      n++;
      frame_start = n == ovr_at;
      if (n == ovr_at) begin
        #1 chk("overrun_pulse", frame_overrun, 1);
      end
    end
    chk("frame_done_in_time", n < limit, 1);
    @(posedge clk); #1 frame_start = 0;
  endtask
  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_err_cnt", err_cnt, 0);
    chk("reset_buf_sel", buf_sel, 0);
    wr_count = 0;
    run_frame(5000, 30000, n);
    chk("frame_a_cycles", n, 24577);
    chk("frame_a_writes", wr_count, 8192);
    chk("frame_a_buf_sel", buf_sel, 1);
    chk("frame_a_err_cnt", err_cnt, 0);
    chk("first_addr", log_addr[0], 13'h0000);
    chk("col1_addr", log_addr[1], 13'h0040);
    chk("last_addr", log_addr[8191], 13'h1FFF);
    chk("col1_color", log_data[1], 12'h001);
    mode = 1; silent_pix = 5; edge_pix = 9; wr_count = 0;
    run_frame(-1, 70000, n);
    chk("frame_b_writes", wr_count, 8192);
    chk("frame_b_buf_sel", buf_sel, 0);
    chk("frame_b_err_cnt", err_cnt, 1);
    chk("timeout_addr", log_addr[5], 13'h0140);
    chk("timeout_data", log_data[5], 12'hF0F);
    chk("edge_rsp_data", log_data[9], 12'h5A5);
    silent_pix = -1; edge_pix = -1; wr_count = 0;
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    n = 0;
    while (pix != 101 && n < 3000) begin
      @(posedge clk); #2;
      n++;
    end
    chk("reached_pixel_100", n < 3000, 1);
    rst = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_wr_en", wr_en, 0);
    chk("abort_err_cnt", err_cnt, 0);
    chk("writes_before_abort", wr_count, 100);
    repeat (4) @(posedge clk);
    #1 rst = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("no_write_after_abort", wr_count, 100);
    chk("idle_after_abort", busy, 0);
    log_addr[0] = 13'h1FFF;
    @(posedge clk); #1 frame_start = 1;
    @(posedge clk); #1 frame_start = 0;
    n = 0;
    while (wr_count < 103 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    chk("restart_writes", wr_count >= 103, 1);
    chk("restart_addr", log_addr[0], 13'h0000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
